// File: rtl/rst_seq_100mhz.sv
// Reset sequencer for the 100 MHz MMCM clock domain.
// Holds the core and peripheral resets until the MMCM lock has been stable
// for LOCK_STABLE_CYCLES. It then releases the core reset first and the
// peripheral reset STAGE_GAP_CYCLES later. A filtered loss of lock re-enters
// WAIT_LOCK and counts the event in a saturating 8-bit counter.
module rst_seq_100mhz #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int LOSS_FILTER_CYCLES = 4
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic       locked,
  output logic       sys_rst_n,
  output logic       periph_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] state
);

  // Each counter carries one spare bit so it can hold its terminal value
  // without wrapping.
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int GW = $clog2(STAGE_GAP_CYCLES) + 1;
  localparam int LW = $clog2(LOSS_FILTER_CYCLES) + 1;

  localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_FILTER_CYCLES);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic          lk_meta_q, lk_sync_q;
  logic          rs_meta_q, rs_sync_q;
  state_t        state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [LW-1:0] loss_q, loss_d;
  logic [7:0]    llc_q, llc_d;
  logic          sys_q, sys_d;
  logic          periph_q, periph_d;
  logic          rdy_q, rdy_d;

  // Two-flop synchronizers: lock indicator, and reset release (assert is async).
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_sync_q <= 1'b0;
      rs_meta_q <= 1'b0;
      rs_sync_q <= 1'b0;
    end else begin
      lk_meta_q <= locked;
      lk_sync_q <= lk_meta_q;
      rs_meta_q <= 1'b1;
      rs_sync_q <= rs_meta_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      stab_q   <= '0;
      gap_q    <= '0;
      loss_q   <= '0;
      llc_q    <= '0;
      sys_q    <= 1'b0;
      periph_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stab_q   <= stab_d;
      gap_q    <= gap_d;
      loss_q   <= loss_d;
      llc_q    <= llc_d;
      sys_q    <= sys_d;
      periph_q <= periph_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state, counter and output decode. A counter that is not
  // meaningful in the next cycle is cleared, so every RELEASE entry starts
  // its gap from zero.
  always_comb begin
    state_d = state_q;
    stab_d  = '0;
    gap_d   = '0;
    loss_d  = '0;
    llc_d   = llc_q;
    unique case (state_q)
      S_RESET: begin
        if (rs_sync_q) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // The transition happens on the edge after the count reaches its target.
        if (stab_q == STAB_MAX) begin
          state_d = S_RELEASE;
        end else if (lk_sync_q) begin
          stab_d = stab_q + SW'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (loss_q == LOSS_MAX) begin
          // A filtered loss takes priority over completing the stage gap.
          state_d = S_WAIT_LOCK;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end else begin
          loss_d = lk_sync_q ? '0 : loss_q + LW'(1);
          if (state_q == S_RELEASE) begin
            if (gap_q == GAP_LAST) state_d = S_RUN;
            else                   gap_d   = gap_q + GW'(1);
          end
        end
      end
      default: state_d = S_RESET;
    endcase
    sys_d    = (state_d == S_RELEASE) || (state_d == S_RUN);
    periph_d = (state_d == S_RUN);
    rdy_d    = (state_d == S_RUN);
  end

  assign sys_rst_n     = sys_q;
  assign periph_rst_n  = periph_q;
  assign ready         = rdy_q;
  assign lock_loss_cnt = llc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_rst_seq_100mhz.sv
// Directed bench for rst_seq_100mhz with LOCK_STABLE=8, STAGE_GAP=4, LOSS_FILTER=3.
// Inputs are driven 1 ns after a rising edge. The next rising edge is the
// first edge that samples them, counted as tick 1.
module tb_rst_seq_100mhz;

  logic       clk_100mhz = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       sys_rst_n;
  logic       periph_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_llc;

  rst_seq_100mhz #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES  (4),
    .LOSS_FILTER_CYCLES(3)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst_n        (rst_n),
    .locked       (locked),
    .sys_rst_n    (sys_rst_n),
    .periph_rst_n (periph_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic s, input logic p,
                          input logic r, input logic [1:0] st);
    chk({tag, ".sys_rst_n"},    sys_rst_n,    s);
    chk({tag, ".periph_rst_n"}, periph_rst_n, p);
    chk({tag, ".ready"},        ready,        r);
    chk({tag, ".state"},        state,        st);
  endtask

  // Bounded wait for a state; an expired budget shows up as a failed check.
  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    int k = 0;
    while (state !== st && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, state, st);
  endtask

  initial begin
    rst_n  = 1'b1;
    locked = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset.llc", lock_loss_cnt, 8'd0);

    // Reset release: two synchronizer edges, then RESET -> WAIT_LOCK on tick 3.
    rst_n = 1'b1;
    tick(2);
    chk("rel.state_t2", state, 2'd0);
    tick(1);
    chk("rel.state_t3", state, 2'd1);

    // Lock rises: sys_rst_n rises on tick 11 (10 edges after the first sample).
    locked = 1'b1;
    tick(10);
    chk_outs("lock.t10", 1'b0, 1'b0, 1'b0, 2'd1);
    tick(1);
    chk_outs("lock.t11", 1'b1, 1'b0, 1'b0, 2'd2);
    tick(3);
    chk_outs("gap.t3", 1'b1, 1'b0, 1'b0, 2'd2);
    tick(1);
    chk_outs("run", 1'b1, 1'b1, 1'b1, 2'd3);
    chk("run.llc", lock_loss_cnt, 8'd0);

    // Two-cycle low in RUN is filtered out.
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(6);
    chk_outs("glitch2", 1'b1, 1'b1, 1'b1, 2'd3);
    chk("glitch2.llc", lock_loss_cnt, 8'd0);

    // Sustained low: everything drops on tick 6 (5 edges after the first low sample).
    locked = 1'b0;
    tick(5);
    chk_outs("loss.t5", 1'b1, 1'b1, 1'b1, 2'd3);
    tick(1);
    chk_outs("loss.t6", 1'b0, 1'b0, 1'b0, 2'd1);
    chk("loss.llc", lock_loss_cnt, 8'd1);

    // WAIT_LOCK: high 6, low 1, high again -> full restart, rise on tick 11 after re-rise.
    locked = 1'b1;
    tick(6);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(10);
    chk_outs("restart.t10", 1'b0, 1'b0, 1'b0, 2'd1);
    chk("restart.llc", lock_loss_cnt, 8'd1);
    tick(1);
    chk_outs("restart.t11", 1'b1, 1'b0, 1'b0, 2'd2);

    // Reset asserted mid-RELEASE acts without a clock edge.
    tick(1);
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("async_rst.llc", lock_loss_cnt, 8'd0);
    tick(1);
    chk_outs("rst_hold", 1'b0, 1'b0, 1'b0, 2'd0);

    // Clean sequence with locked held high through the release.
    rst_n = 1'b1;
    tick(3);
    chk("clean.state_t3", state, 2'd1);
    tick(8);
    chk_outs("clean.t11", 1'b0, 1'b0, 1'b0, 2'd1);
    tick(1);
    chk_outs("clean.t12", 1'b1, 1'b0, 1'b0, 2'd2);
    tick(4);
    chk_outs("clean.run", 1'b1, 1'b1, 1'b1, 2'd3);
    chk("clean.llc", lock_loss_cnt, 8'd0);

    // Repeated filtered losses: the counter saturates at 255.
    exp_llc = 0;
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      wait_state("rep.to_wait", 2'd1, 20);
      if (exp_llc < 255) exp_llc++;
      chk("rep.llc", lock_loss_cnt, exp_llc);
      locked = 1'b1;
      wait_state("rep.to_run", 2'd3, 40);
    end
    chk("sat.llc", lock_loss_cnt, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
